// File: rtl/decode_execute_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle bit
// positions, the hard-wired zero register, and the per-edge action encoding.
package decode_execute_reg_pkg;

    // Control bundle layout, common to decode and execute.
    localparam int CTRL_W          = 12;
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_JUMP       = 6;
    localparam int CTRL_ALU_OP_LSB = 7;
    localparam int CTRL_ALU_OP_MSB = 10;
    localparam int CTRL_LINK       = 11;

    // Register 0 reads as zero and is never a bypass target.
    localparam int ZERO_REG = 0;

    // What the register does on a given edge, once reset has been excluded.
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } stage_act_e;

endpackage : decode_execute_reg_pkg

// File: rtl/decode_execute_reg_operand_bypass.sv
// Combinational write-back bypass for one operand. The reg_file commits on the
// clock edge, so a read in the same cycle as a write returns the old value;
// this substitutes the write-back data when the IDs match (never for r0).
module operand_bypass
    import decode_execute_reg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5
) (
    input  logic [REG_ID_W-1:0] sel_id,
    input  logic [DATA_W-1:0]   cur_val,
    input  logic                wb_write,
    input  logic [REG_ID_W-1:0] wb_reg_id,
    input  logic [DATA_W-1:0]   wb_val,
    output logic [DATA_W-1:0]   val
);

    logic hit;

    // Match on a live write to a non-zero register with the selected ID.
    always_comb begin
        hit = wb_write && (wb_reg_id == sel_id) && (sel_id != REG_ID_W'(ZERO_REG));
        val = hit ? wb_val : cur_val;
    end

endmodule : operand_bypass

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register. Captures the decode bundle, keeps both operands
// coherent with a same-cycle write-back on capture and while stalled, inserts
// bubbles on flush or invalid decode, and counts those bubbles (saturating).
module decode_execute_reg
    import decode_execute_reg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5,
    parameter int CTRL_W   = decode_execute_reg_pkg::CTRL_W,
    parameter int COUNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [REG_ID_W-1:0] in_rs_id,
    input  logic [REG_ID_W-1:0] in_rt_id,
    input  logic [REG_ID_W-1:0] in_rd_id,
    input  logic [DATA_W-1:0]   in_rs_val,
    input  logic [DATA_W-1:0]   in_rt_val,
    input  logic [DATA_W-1:0]   in_imm,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic                wb_write,
    input  logic [REG_ID_W-1:0] wb_reg_id,
    input  logic [DATA_W-1:0]   wb_val,
    output logic                out_valid,
    output logic [REG_ID_W-1:0] out_rs_id,
    output logic [REG_ID_W-1:0] out_rt_id,
    output logic [REG_ID_W-1:0] out_rd_id,
    output logic [DATA_W-1:0]   out_rs_val,
    output logic [DATA_W-1:0]   out_rt_val,
    output logic [DATA_W-1:0]   out_imm,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [COUNT_W-1:0]  bubble_count
);

    logic                valid_q,  valid_d;
    logic [REG_ID_W-1:0] rs_id_q,  rs_id_d;
    logic [REG_ID_W-1:0] rt_id_q,  rt_id_d;
    logic [REG_ID_W-1:0] rd_id_q,  rd_id_d;
    logic [DATA_W-1:0]   rs_val_q, rs_val_d;
    logic [DATA_W-1:0]   rt_val_q, rt_val_d;
    logic [DATA_W-1:0]   imm_q,    imm_d;
    logic [CTRL_W-1:0]   ctrl_q,   ctrl_d;
    logic [COUNT_W-1:0]  count_q,  count_d;

    stage_act_e          act;
    logic                bubble_inc;

    logic [REG_ID_W-1:0] rs_sel_id, rt_sel_id;
    logic [DATA_W-1:0]   rs_cur,    rt_cur;
    logic [DATA_W-1:0]   rs_byp,    rt_byp;

    // Flush beats stall; stall beats load.
    always_comb begin
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_HOLD;
        end else begin
            act = ACT_LOAD;
        end
    end

    // One bypass per operand, shared by capture (decode inputs) and hold
    // (currently registered ID/value).
    always_comb begin
        if (act == ACT_HOLD) begin
            rs_sel_id = rs_id_q;
            rt_sel_id = rt_id_q;
            rs_cur    = rs_val_q;
            rt_cur    = rt_val_q;
        end else begin
            rs_sel_id = in_rs_id;
            rt_sel_id = in_rt_id;
            rs_cur    = in_rs_val;
            rt_cur    = in_rt_val;
        end
    end

    operand_bypass #(
        .DATA_W   (DATA_W),
        .REG_ID_W (REG_ID_W)
    ) u_rs_bypass (
        .sel_id    (rs_sel_id),
        .cur_val   (rs_cur),
        .wb_write  (wb_write),
        .wb_reg_id (wb_reg_id),
        .wb_val    (wb_val),
        .val       (rs_byp)
    );

    operand_bypass #(
        .DATA_W   (DATA_W),
        .REG_ID_W (REG_ID_W)
    ) u_rt_bypass (
        .sel_id    (rt_sel_id),
        .cur_val   (rt_cur),
        .wb_write  (wb_write),
        .wb_reg_id (wb_reg_id),
        .wb_val    (wb_val),
        .val       (rt_byp)
    );

    // Next-state selection for the bundle and the bubble counter.
    always_comb begin
        valid_d    = valid_q;
        rs_id_d    = rs_id_q;
        rt_id_d    = rt_id_q;
        rd_id_d    = rd_id_q;
        rs_val_d   = rs_val_q;
        rt_val_d   = rt_val_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        bubble_inc = 1'b0;

        unique case (act)
            ACT_FLUSH: begin
                valid_d    = 1'b0;
                rs_id_d    = '0;
                rt_id_d    = '0;
                rd_id_d    = '0;
                rs_val_d   = '0;
                rt_val_d   = '0;
                imm_d      = '0;
                ctrl_d     = '0;
                bubble_inc = 1'b1;
            end
            ACT_HOLD: begin
                // Fields hold, but a held operand still tracks write-back so a
                // long stall cannot leave a stale value behind.
                rs_val_d = rs_byp;
                rt_val_d = rt_byp;
            end
            default: begin
                valid_d    = in_valid;
                rs_id_d    = in_rs_id;
                rt_id_d    = in_rt_id;
                rd_id_d    = in_rd_id;
                rs_val_d   = rs_byp;
                rt_val_d   = rt_byp;
                imm_d      = in_imm;
                ctrl_d     = in_valid ? in_ctrl : '0;
                bubble_inc = !in_valid;
            end
        endcase

        // Saturate rather than wrap so a long run still reads as "many".
        if (bubble_inc && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            rs_id_q  <= '0;
            rt_id_q  <= '0;
            rd_id_q  <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rs_id_q  <= rs_id_d;
            rt_id_q  <= rt_id_d;
            rd_id_q  <= rd_id_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_rs_id    = rs_id_q;
    assign out_rt_id    = rt_id_q;
    assign out_rd_id    = rd_id_q;
    assign out_rs_val   = rs_val_q;
    assign out_rt_val   = rt_val_q;
    assign out_imm      = imm_q;
    assign out_ctrl     = ctrl_q;
    assign bubble_count = count_q;

endmodule : decode_execute_reg

// File: tb/tb_decode_execute_reg.sv
// Bench for the ID/EX register: directed vectors, a narrow-counter instance
// for saturation, and a short randomized stream checked against a reg file.
module tb_decode_execute_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 12;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          stall, flush, in_valid;
    logic [RW-1:0] in_rs_id, in_rt_id, in_rd_id;
    logic [DW-1:0] in_rs_val, in_rt_val, in_imm;
    logic [CW-1:0] in_ctrl;
    logic          wb_write;
    logic [RW-1:0] wb_reg_id;
    logic [DW-1:0] wb_val;

    logic          out_valid;
    logic [RW-1:0] out_rs_id, out_rt_id, out_rd_id;
    logic [DW-1:0] out_rs_val, out_rt_val, out_imm;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   bubble_count;

    logic          s_valid;
    logic [RW-1:0] s_rs_id, s_rt_id, s_rd_id;
    logic [DW-1:0] s_rs_val, s_rt_val, s_imm;
    logic [CW-1:0] s_ctrl;
    logic [3:0]    s_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rf [0:31];
    logic [RW-1:0] e_rs_id, e_rt_id;
    logic          e_valid;
    logic [CW-1:0] e_ctrl;
    logic [15:0]   e_cnt;
    logic [3:0]    e_cnt4;

    always #5 clock = ~clock;

    decode_execute_reg dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rs_id(in_rs_id), .in_rt_id(in_rt_id), .in_rd_id(in_rd_id),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .wb_write(wb_write), .wb_reg_id(wb_reg_id), .wb_val(wb_val),
        .out_valid(out_valid), .out_rs_id(out_rs_id), .out_rt_id(out_rt_id), .out_rd_id(out_rd_id),
        .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm), .out_ctrl(out_ctrl),
        .bubble_count(bubble_count)
    );

    decode_execute_reg #(.COUNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rs_id(in_rs_id), .in_rt_id(in_rt_id), .in_rd_id(in_rd_id),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .wb_write(wb_write), .wb_reg_id(wb_reg_id), .wb_val(wb_val),
        .out_valid(s_valid), .out_rs_id(s_rs_id), .out_rt_id(s_rt_id), .out_rd_id(s_rd_id),
        .out_rs_val(s_rs_val), .out_rt_val(s_rt_val), .out_imm(s_imm), .out_ctrl(s_ctrl),
        .bubble_count(s_count)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; the reference reg file and the ID/valid/ctrl/count
    // expectations follow the inputs presented before the edge.
    task automatic tick();
        if (!reset_n) begin
            e_valid = 1'b0; e_rs_id = '0; e_rt_id = '0; e_ctrl = '0;
            e_cnt = '0; e_cnt4 = '0;
        end else if (flush) begin
            e_valid = 1'b0; e_rs_id = '0; e_rt_id = '0; e_ctrl = '0;
            if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            if (e_cnt4 != 4'hF) e_cnt4 = e_cnt4 + 4'd1;
        end else if (!stall) begin
            e_valid = in_valid; e_rs_id = in_rs_id; e_rt_id = in_rt_id;
            e_ctrl = in_valid ? in_ctrl : '0;
            if (!in_valid) begin
                if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
                if (e_cnt4 != 4'hF) e_cnt4 = e_cnt4 + 4'd1;
            end
        end
        if (wb_write && wb_reg_id != 0) rf[wb_reg_id] = wb_val;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; in_valid = 1;
        in_rs_id = 0; in_rt_id = 0; in_rd_id = 0;
        in_rs_val = 0; in_rt_val = 0; in_imm = 0; in_ctrl = 0;
        wb_write = 0; wb_reg_id = 0; wb_val = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        idle_inputs();

        // 1: reset dominates a valid bundle, then first load lands next edge
        reset_n = 0; in_valid = 1; in_rs_val = 5; in_ctrl = 12'hABC; flush = 1;
        tick();
        chk_eq("rst_valid", out_valid, 0);
        chk_eq("rst_rs_val", out_rs_val, 0);
        chk_eq("rst_ctrl", out_ctrl, 0);
        chk_eq("rst_count", bubble_count, 0);
        reset_n = 1; flush = 0; in_rs_id = 3; in_rs_val = 5; in_rd_id = 9;
        in_imm = 32'hFFFF_FFF0; in_ctrl = 12'h5A5;
        tick();
        chk_eq("load_valid", out_valid, 1);
        chk_eq("load_rs_val", out_rs_val, 5);
        chk_eq("load_rs_id", out_rs_id, 3);
        chk_eq("load_rd_id", out_rd_id, 9);
        chk_eq("load_imm", out_imm, 32'hFFFF_FFF0);
        chk_eq("load_ctrl", out_ctrl, 12'h5A5);

        // 2: capture bypass, both operands on same ID, and r0 never bypassed
        in_rs_id = 1; in_rs_val = 5; in_rt_id = 4; in_rt_val = 6;
        wb_write = 1; wb_reg_id = 1; wb_val = 30;
        tick();
        chk_eq("cap_byp_rs", out_rs_val, 30);
        chk_eq("cap_nobyp_rt", out_rt_val, 6);
        in_rt_id = 1; in_rt_val = 5;
        tick();
        chk_eq("cap_same_rs", out_rs_val, 30);
        chk_eq("cap_same_rt", out_rt_val, 30);
        in_rs_id = 0; in_rs_val = 5; in_rt_id = 2; in_rt_val = 8; wb_reg_id = 0;
        tick();
        chk_eq("cap_r0_rs", out_rs_val, 5);
        chk_eq("cap_wbwr0_rt", out_rt_val, 8);

        // 3: held operand follows write-back during a 3-cycle stall
        wb_write = 0; in_rs_id = 7; in_rs_val = 11; in_rt_id = 2; in_rt_val = 4;
        in_rd_id = 6; in_ctrl = 12'h0F1;
        tick();
        stall = 1; in_rs_id = 13; in_rs_val = 99; in_rt_id = 14; in_rt_val = 98; in_ctrl = 12'hFFF;
        tick();
        chk_eq("stall1_rt", out_rt_val, 4);
        wb_write = 1; wb_reg_id = 2; wb_val = 29;
        tick();
        wb_write = 0;
        tick();
        chk_eq("stall_byp_rt", out_rt_val, 29);
        chk_eq("stall_rs_val", out_rs_val, 11);
        chk_eq("stall_rs_id", out_rs_id, 7);
        chk_eq("stall_rt_id", out_rt_id, 2);
        chk_eq("stall_ctrl", out_ctrl, 12'h0F1);
        chk_eq("stall_valid", out_valid, 1);
        chk_eq("stall_count", bubble_count, 0);

        // 4: flush during stall wins, held bubble does not count, load restores
        flush = 1;
        tick();
        chk_eq("flush_valid", out_valid, 0);
        chk_eq("flush_ctrl", out_ctrl, 0);
        chk_eq("flush_rt_val", out_rt_val, 0);
        chk_eq("flush_count", bubble_count, 1);
        flush = 0;
        tick();
        chk_eq("hold_bub_valid", out_valid, 0);
        chk_eq("hold_bub_count", bubble_count, 1);
        stall = 0; in_ctrl = 12'h123;
        tick();
        chk_eq("restore_valid", out_valid, 1);
        chk_eq("restore_ctrl", out_ctrl, 12'h123);
        in_valid = 0;
        tick();
        chk_eq("inval_valid", out_valid, 0);
        chk_eq("inval_ctrl", out_ctrl, 0);
        chk_eq("inval_count", bubble_count, 2);

        // 5: 20 further flushes; the 4-bit instance saturates at 15
        in_valid = 1; flush = 1;
        for (int i = 0; i < 20; i++) tick();
        chk_eq("sat_count16", bubble_count, 22);
        chk_eq("sat_count4", s_count, 15);
        tick();
        chk_eq("sat_hold4", s_count, 15);
        chk_eq("sat_count16b", bubble_count, 23);

        // 6: random stream; each operand must equal the reference reg file
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        for (int cyc = 0; cyc < 300; cyc++) begin
            flush     = (cyc == 0) || ($urandom_range(0, 9) == 0);
            stall     = ($urandom_range(0, 9) < 3);
            in_valid  = ($urandom_range(0, 9) < 8);
            in_rs_id  = RW'($urandom_range(0, 7));
            in_rt_id  = RW'($urandom_range(0, 7));
            in_rd_id  = RW'($urandom_range(0, 31));
            in_rs_val = rf[in_rs_id];
            in_rt_val = rf[in_rt_id];
            in_imm    = $urandom;
            in_ctrl   = CW'($urandom);
            wb_write  = ($urandom_range(0, 1) == 1);
            wb_reg_id = RW'($urandom_range(0, 7));
            wb_val    = $urandom;
            tick();
            chk_eq("rnd_rs_id", out_rs_id, e_rs_id);
            chk_eq("rnd_rt_id", out_rt_id, e_rt_id);
            chk_eq("rnd_rs_val", out_rs_val, rf[out_rs_id]);
            chk_eq("rnd_rt_val", out_rt_val, rf[out_rt_id]);
            chk_eq("rnd_valid", out_valid, e_valid);
            chk_eq("rnd_ctrl", out_ctrl, e_ctrl);
            chk_eq("rnd_count", bubble_count, e_cnt);
            chk_eq("rnd_count4", s_count, e_cnt4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_decode_execute_reg
